// File: rtl/neighbor_link_ctx.sv
// Edge between two lattice PEs with saturating growth, error flag and boundary state,
// multiplexed over NUM_CONTEXTS syndrome contexts (live in registers, idle contexts in RAM).
module neighbor_link_ctx #(
    parameter int ADDRESS_WIDTH = 6,
    parameter int MAX_WEIGHT    = 2,
    parameter int NUM_CONTEXTS  = 4,
    localparam int EXPOSED_DATA_SIZE = ADDRESS_WIDTH + 3,
    localparam int WW = (MAX_WEIGHT > 0) ? $clog2(MAX_WEIGHT + 1) : 1,
    localparam int CW = (NUM_CONTEXTS > 2) ? $clog2(NUM_CONTEXTS) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         a_increase,
    input  logic                         b_increase,
    input  logic [WW-1:0]                weight_in,
    input  logic [1:0]                   boundary_condition_in,
    input  logic                         a_is_error_in,
    input  logic                         b_is_error_in,
    input  logic                         is_error_systolic_in,
    input  logic                         load_result,
    input  logic                         reset_edge,
    input  logic [EXPOSED_DATA_SIZE-1:0] a_input_data,
    input  logic [EXPOSED_DATA_SIZE-1:0] b_input_data,
    output logic [EXPOSED_DATA_SIZE-1:0] a_output_data,
    output logic [EXPOSED_DATA_SIZE-1:0] b_output_data,
    input  logic                         ctx_req,
    input  logic [CW-1:0]                ctx_target,
    input  logic                         ctx_no_save,
    output logic                         ctx_busy,
    output logic                         ctx_done,
    output logic [CW-1:0]                cur_ctx,
    output logic [WW-1:0]                growth_out,
    output logic [WW-1:0]                weight_out,
    output logic [1:0]                   boundary_condition_out,
    output logic                         fully_grown,
    output logic                         is_boundary,
    output logic                         is_error
);

    typedef enum logic [1:0] {S_IDLE, S_SAVE, S_READ, S_APPLY} state_t;

    state_t state_reg, state_next;

    logic [WW-1:0]           growth_reg;
    logic                    is_error_reg;
    logic [WW-1:0]           weight_reg;
    logic [1:0]              bc_reg;
    logic [CW-1:0]           cur_ctx_reg;
    logic [CW-1:0]           target_reg;
    logic                    no_save_reg;
    logic [NUM_CONTEXTS-1:0] valid_reg;
    logic [NUM_CONTEXTS-1:0] valid_set;

    // Each RAM word packs {growth, is_error}
    logic [WW:0]   mem [NUM_CONTEXTS];
    logic [WW:0]   rd_data_reg;
    logic [CW-1:0] mem_addr;
    logic [WW:0]   mem_wdata;
    logic          mem_we;

    logic [WW+1:0] sum_next;
    logic [WW-1:0] growth_next;
    logic          is_error_next;
    logic [WW-1:0] rd_growth;
    logic [WW-1:0] load_growth;
    logic          load_error;

    // ---------------- context-switch FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            target_reg  <= '0;
            no_save_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_IDLE && ctx_req) begin
                target_reg  <= ctx_target;
                no_save_reg <= ctx_no_save;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        ctx_done   = 1'b0;
        mem_we     = 1'b0;
        case (state_reg)
            S_IDLE:  if (ctx_req) state_next = S_SAVE;
            S_SAVE: begin
                mem_we     = !no_save_reg;
                state_next = S_READ;
            end
            S_READ:  state_next = S_APPLY;
            S_APPLY: begin
                ctx_done   = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign ctx_busy = (state_reg != S_IDLE);

    // ---------------- context RAM ----------------
    // A reset_edge coinciding with SAVE stores the cleared state, matching the live registers.
    assign mem_addr  = (state_reg == S_SAVE) ? cur_ctx_reg : target_reg;
    assign mem_wdata = reset_edge ? '0 : {growth_reg, is_error_reg};

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        rd_data_reg <= mem[mem_addr];
    end

    generate
        for (genvar gi = 0; gi < NUM_CONTEXTS; gi++) begin : g_valid
            assign valid_set[gi] = mem_we && (cur_ctx_reg == CW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) valid_reg <= '0;
        else       valid_reg <= valid_reg | valid_set;
    end

    assign rd_growth   = rd_data_reg[WW:1];
    assign load_growth = !valid_reg[target_reg] ? '0 :
                         (rd_growth > weight_reg) ? weight_reg : rd_growth;
    assign load_error  = valid_reg[target_reg] && rd_data_reg[0];

    // ---------------- edge update ----------------
    always_comb begin
        sum_next      = '0;
        is_error_next = 1'b0;
        case (bc_reg)
            2'd0, 2'd3: begin
                sum_next      = (WW+2)'(growth_reg) + (WW+2)'(a_increase) + (WW+2)'(b_increase);
                is_error_next = a_is_error_in | b_is_error_in;
            end
            2'd1: begin
                sum_next      = (WW+2)'(growth_reg) + (WW+2)'(a_increase);
                is_error_next = a_is_error_in;
            end
            default: begin
                sum_next      = '0;
                is_error_next = 1'b0;
            end
        endcase
    end

    assign growth_next = (sum_next > (WW+2)'(weight_reg)) ? weight_reg : sum_next[WW-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            weight_reg <= '0;
            bc_reg     <= '0;
        end else begin
            weight_reg <= weight_in;
            bc_reg     <= boundary_condition_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            growth_reg   <= '0;
            is_error_reg <= 1'b0;
            cur_ctx_reg  <= '0;
        end else begin
            if (state_reg == S_APPLY) cur_ctx_reg <= target_reg;
            if (reset_edge) begin
                growth_reg   <= '0;
                is_error_reg <= 1'b0;
            end else if (state_reg == S_APPLY) begin
                growth_reg   <= load_growth;
                is_error_reg <= load_error;
            end else if (ctx_busy) begin
                growth_reg   <= growth_reg;
                is_error_reg <= is_error_reg;
            end else begin
                growth_reg   <= growth_next;
                is_error_reg <= load_result ? is_error_systolic_in : is_error_next;
            end
        end
    end

    // ---------------- outputs ----------------
    assign cur_ctx                = cur_ctx_reg;
    assign growth_out             = growth_reg;
    assign weight_out             = weight_reg;
    assign boundary_condition_out = bc_reg;
    assign is_error               = is_error_reg;
    assign fully_grown            = (growth_reg >= weight_reg) && (bc_reg != 2'd2);
    assign is_boundary            = fully_grown && (bc_reg == 2'd1 || bc_reg == 2'd3);
    assign a_output_data          = (bc_reg == 2'd0) ? b_input_data : '0;
    assign b_output_data          = (bc_reg == 2'd0) ? a_input_data : '0;

endmodule

// File: tb/tb_neighbor_link_ctx.sv
// Directed bench for neighbor_link_ctx: table of single-cycle edge updates followed by
// hand-written context-switch sequences.
module tb_neighbor_link_ctx;

    localparam int AW  = 6;
    localparam int EDS = AW + 3;
    localparam int WW  = 2;
    localparam int CW  = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic           a_increase, b_increase;
    logic [WW-1:0]  weight_in;
    logic [1:0]     boundary_condition_in;
    logic           a_is_error_in, b_is_error_in;
    logic           is_error_systolic_in, load_result, reset_edge;
    logic [EDS-1:0] a_input_data, b_input_data, a_output_data, b_output_data;
    logic           ctx_req, ctx_no_save, ctx_busy, ctx_done;
    logic [CW-1:0]  ctx_target, cur_ctx;
    logic [WW-1:0]  growth_out, weight_out;
    logic [1:0]     boundary_condition_out;
    logic           fully_grown, is_boundary, is_error;

    int checks = 0;
    int errors = 0;

    neighbor_link_ctx #(.ADDRESS_WIDTH(AW), .MAX_WEIGHT(2), .NUM_CONTEXTS(4)) dut (
        .clk(clk), .reset(reset),
        .a_increase(a_increase), .b_increase(b_increase),
        .weight_in(weight_in), .boundary_condition_in(boundary_condition_in),
        .a_is_error_in(a_is_error_in), .b_is_error_in(b_is_error_in),
        .is_error_systolic_in(is_error_systolic_in), .load_result(load_result),
        .reset_edge(reset_edge),
        .a_input_data(a_input_data), .b_input_data(b_input_data),
        .a_output_data(a_output_data), .b_output_data(b_output_data),
        .ctx_req(ctx_req), .ctx_target(ctx_target), .ctx_no_save(ctx_no_save),
        .ctx_busy(ctx_busy), .ctx_done(ctx_done), .cur_ctx(cur_ctx),
        .growth_out(growth_out), .weight_out(weight_out),
        .boundary_condition_out(boundary_condition_out),
        .fully_grown(fully_grown), .is_boundary(is_boundary), .is_error(is_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       a, b, ae, be;
        logic [1:0] bc;
        logic [1:0] w;
        logic       le, sys, re;
        logic [1:0] eg;
        logic       ee, efg, ebd;
    } vec_t;

    vec_t vt[16];

    function automatic vec_t mk(input int a, b, ae, be, bc, w, le, sys, re, eg, ee, efg, ebd);
        vec_t v;
        v.a = a[0]; v.b = b[0]; v.ae = ae[0]; v.be = be[0];
        v.bc = bc[1:0]; v.w = w[1:0]; v.le = le[0]; v.sys = sys[0]; v.re = re[0];
        v.eg = eg[1:0]; v.ee = ee[0]; v.efg = efg[0]; v.ebd = ebd[0];
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Full switch: busy t+1..t+3, done only at t+3, new context live at t+4
    task automatic do_switch(input int tgt, input bit ns);
        ctx_req = 1'b1; ctx_target = CW'(tgt); ctx_no_save = ns;
        tick;
        ctx_req = 1'b0; ctx_no_save = 1'b0;
        chk("sw_busy1", ctx_busy, 1); chk("sw_done1", ctx_done, 0);
        tick;
        chk("sw_busy2", ctx_busy, 1); chk("sw_done2", ctx_done, 0);
        tick;
        chk("sw_busy3", ctx_busy, 1); chk("sw_done3", ctx_done, 1);
        tick;
        chk("sw_busy4", ctx_busy, 0); chk("sw_done4", ctx_done, 0);
        chk("sw_cur", cur_ctx, tgt);
        $display("switch to ctx %0d no_save %0d: growth %0d is_error %0d", tgt, ns, growth_out, is_error);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick; tick;
        chk("rst_growth", growth_out, 0); chk("rst_err", is_error, 0);
        chk("rst_weight", weight_out, 0); chk("rst_bc", boundary_condition_out, 0);
        chk("rst_cur", cur_ctx, 0); chk("rst_busy", ctx_busy, 0); chk("rst_done", ctx_done, 0);
        reset = 1'b0;
    endtask

    initial begin
        int done_cnt;
        reset = 1'b1; a_increase = 0; b_increase = 0; weight_in = 0; boundary_condition_in = 0;
        a_is_error_in = 0; b_is_error_in = 0; is_error_systolic_in = 0; load_result = 0;
        reset_edge = 0; a_input_data = '0; b_input_data = '0;
        ctx_req = 0; ctx_target = '0; ctx_no_save = 0;

        //          a b ae be bc w le sys re  eg ee fg bd
        vt[0]  = mk(0,0,0,0, 0,2, 0,0,0,  0,0,0,0);
        vt[1]  = mk(1,1,0,0, 0,2, 0,0,0,  2,0,1,0);
        vt[2]  = mk(1,1,0,0, 0,2, 0,0,0,  2,0,1,0);
        vt[3]  = mk(0,0,0,0, 1,2, 0,0,1,  0,0,0,0);
        vt[4]  = mk(0,1,0,1, 1,2, 0,0,0,  0,0,0,0);
        vt[5]  = mk(1,0,1,0, 1,2, 0,0,0,  1,1,0,0);
        vt[6]  = mk(1,0,0,0, 1,2, 0,0,0,  2,0,1,1);
        vt[7]  = mk(1,1,1,0, 2,2, 0,0,0,  2,1,0,0);
        vt[8]  = mk(1,1,1,1, 2,2, 0,0,0,  0,0,0,0);
        vt[9]  = mk(1,0,0,0, 3,2, 0,0,0,  0,0,0,0);
        vt[10] = mk(1,0,0,1, 3,2, 0,0,0,  1,1,0,0);
        vt[11] = mk(0,1,0,0, 3,2, 0,0,0,  2,0,1,1);
        vt[12] = mk(0,0,0,0, 3,2, 1,1,0,  2,1,1,1);
        vt[13] = mk(0,0,1,0, 3,2, 1,0,0,  2,0,1,1);
        vt[14] = mk(0,0,0,0, 0,1, 0,0,0,  2,0,1,0);
        vt[15] = mk(0,0,0,0, 0,1, 0,0,0,  1,0,1,0);

        do_reset;

        for (int i = 0; i < 16; i++) begin
            a_increase = vt[i].a; b_increase = vt[i].b;
            a_is_error_in = vt[i].ae; b_is_error_in = vt[i].be;
            boundary_condition_in = vt[i].bc; weight_in = vt[i].w;
            load_result = vt[i].le; is_error_systolic_in = vt[i].sys; reset_edge = vt[i].re;
            tick;
            $display("vec %0d: growth %0d is_error %0d fully_grown %0d is_boundary %0d",
                     i, growth_out, is_error, fully_grown, is_boundary);
            chk($sformatf("vec%0d_growth", i), growth_out, vt[i].eg);
            chk($sformatf("vec%0d_err", i), is_error, vt[i].ee);
            chk($sformatf("vec%0d_fg", i), fully_grown, vt[i].efg);
            chk($sformatf("vec%0d_bnd", i), is_boundary, vt[i].ebd);
            chk($sformatf("vec%0d_w", i), weight_out, vt[i].w);
            chk($sformatf("vec%0d_bc", i), boundary_condition_out, vt[i].bc);
        end
        a_increase = 0; b_increase = 0; a_is_error_in = 0; b_is_error_in = 0;
        load_result = 0; is_error_systolic_in = 0; reset_edge = 0;

        // Data crossing: bc 0 swaps, any other bc gives zero
        a_input_data = 9'h1A5; b_input_data = 9'h04C;
        #1;
        chk("xdata_a_bc0", a_output_data, 9'h04C); chk("xdata_b_bc0", b_output_data, 9'h1A5);
        boundary_condition_in = 2'd1;
        tick;
        chk("xdata_a_bc1", a_output_data, 0); chk("xdata_b_bc1", b_output_data, 0);
        $display("data crossing: a_out %0h b_out %0h", a_output_data, b_output_data);

        // Context save/restore
        do_reset;
        weight_in = 2; boundary_condition_in = 0;
        tick;
        a_increase = 1; a_is_error_in = 1;
        tick;
        a_increase = 0;
        chk("ctx0_growth", growth_out, 1); chk("ctx0_err", is_error, 1);
        do_switch(2, 0);
        a_is_error_in = 0;
        chk("ctx2_growth", growth_out, 0); chk("ctx2_err", is_error, 0);
        do_switch(0, 0);
        chk("ctx0_back_growth", growth_out, 1); chk("ctx0_back_err", is_error, 1);

        // Discarding live state with no_save
        do_switch(1, 0);
        chk("ctx1_empty", growth_out, 0);
        a_increase = 1; b_increase = 1;
        tick;
        a_increase = 0; b_increase = 0;
        chk("ctx1_grown", growth_out, 2);
        do_switch(0, 1);
        chk("ns_ctx0_growth", growth_out, 1); chk("ns_ctx0_err", is_error, 0);
        do_switch(1, 0);
        chk("ns_ctx1_growth", growth_out, 0);

        // Requests and growth inputs during a switch are ignored
        a_increase = 1;
        tick;
        a_increase = 0;
        chk("busy_pre_growth", growth_out, 1);
        done_cnt = 0;
        ctx_req = 1; ctx_target = 2'd3;
        tick;
        ctx_target = 2'd2; a_increase = 1; b_increase = 1;
        for (int c = 1; c <= 7; c++) begin
            if (c == 2) ctx_req = 0;
            if (c == 3) begin a_increase = 0; b_increase = 0; end
            if (ctx_done) done_cnt++;
            if (c <= 3) chk($sformatf("busy_hold_growth_c%0d", c), growth_out, 1);
            if (c == 4) begin
                chk("busy_cur", cur_ctx, 3); chk("busy_new_growth", growth_out, 0);
            end
            if (c >= 4) chk($sformatf("busy_idle_c%0d", c), ctx_busy, 0);
            tick;
        end
        chk("busy_done_count", done_cnt, 1);
        $display("busy test: done pulses %0d cur_ctx %0d", done_cnt, cur_ctx);

        // target == cur_ctx reloads what was just saved
        a_increase = 1; a_is_error_in = 1;
        tick;
        a_increase = 0;
        do_switch(3, 0);
        chk("self_growth", growth_out, 1); chk("self_err", is_error, 1);
        a_is_error_in = 0;

        // reset_edge during SAVE stores cleared state
        ctx_req = 1; ctx_target = 2'd1;
        tick;
        ctx_req = 0;
        chk("re_save_pre", growth_out, 1);
        reset_edge = 1;
        tick;
        reset_edge = 0;
        chk("re_save_live", growth_out, 0);
        tick; tick;
        chk("re_save_cur", cur_ctx, 1);
        do_switch(3, 0);
        chk("re_save_stored", growth_out, 0);

        // reset in READ returns to IDLE and empties every context
        a_increase = 1;
        tick;
        a_increase = 0;
        chk("rr_pre_growth", growth_out, 1);
        ctx_req = 1; ctx_target = 2'd0;
        tick;
        ctx_req = 0;
        tick;
        chk("rr_in_read", ctx_busy, 1);
        reset = 1;
        tick;
        reset = 0;
        chk("rr_busy", ctx_busy, 0); chk("rr_done", ctx_done, 0);
        chk("rr_cur", cur_ctx, 0); chk("rr_growth", growth_out, 0);
        tick;
        do_switch(3, 0);
        chk("rr_ctx3_empty", growth_out, 0);
        do_switch(1, 0);
        chk("rr_ctx1_empty", growth_out, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
